// File: rtl/bp_be_issue_buffer.sv
// Speculative issue buffer: in-order entries with separate write, dispatch (read) and commit pointers; define BP_BE_ISSUE_BUFFER_BYPASS_EN for same-cycle enq-to-issue bypass.
// Latency: one cycle enqueue-to-issue (zero with bypass); full/empty credits come from registered pointers only.
// Backpressure: enqueues are dropped while credits_full_o is high; space is only reclaimed on commit, so replay can re-issue.
module bp_be_issue_buffer #(
    parameter int els_p        = 8,
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enq_v_i,
    input  logic [data_width_p-1:0] enq_data_i,
    input  logic                    deq_v_i,
    input  logic                    commit_v_i,
    input  logic                    roll_v_i,
    input  logic                    clr_v_i,
    output logic                    issue_v_o,
    output logic [data_width_p-1:0] issue_data_o,
    output logic                    credits_full_o,
    output logic                    credits_empty_o
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;
    localparam logic [ptr_w-1:0] full_cnt = ptr_w'(els_p);

    logic [data_width_p-1:0] mem [els_p];

    logic [ptr_w-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_w-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_w-1:0] held;

    logic flush;
    logic enq_acc, deq_acc, commit_acc;
    logic stored_v;

    // Pointer MSB is the wrap bit: equal indices with differing wrap bits means full.
    assign held            = wptr_r - cptr_r;
    assign credits_full_o  = (held == full_cnt);
    assign credits_empty_o = (wptr_r == cptr_r);

    assign flush      = reset_i | clr_v_i;
    assign enq_acc    = enq_v_i & ~credits_full_o;
    assign stored_v   = (rptr_r != wptr_r);
    assign commit_acc = commit_v_i & (cptr_r != rptr_r);
    assign deq_acc    = deq_v_i & issue_v_o;

`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
    always_comb begin
        issue_v_o    = stored_v | enq_acc;
        issue_data_o = stored_v ? mem[rptr_r[idx_w-1:0]] : enq_data_i;
    end
`else
    always_comb begin
        issue_v_o    = stored_v;
        issue_data_o = mem[rptr_r[idx_w-1:0]];
    end
`endif

    always_comb begin
        wptr_n = wptr_r;
        rptr_n = rptr_r;
        cptr_n = cptr_r;
        if (flush) begin
            wptr_n = '0;
            rptr_n = '0;
            cptr_n = '0;
        end else begin
            wptr_n = wptr_r + ptr_w'(enq_acc);
            cptr_n = cptr_r + ptr_w'(commit_acc);
            // Replay lands on where the commit pointer will be, including a same-cycle retire.
            if (roll_v_i)
                rptr_n = cptr_r + ptr_w'(commit_acc);
            else
                rptr_n = rptr_r + ptr_w'(deq_acc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_acc && !flush)
            mem[wptr_r[idx_w-1:0]] <= enq_data_i;
    end

endmodule

// File: tb/tb_bp_be_issue_buffer.sv
// Directed bench for bp_be_issue_buffer at els_p=8, data_width_p=32.
module tb_bp_be_issue_buffer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enq_v_i = 1'b0;
    logic [31:0] enq_data_i = '0;
    logic        deq_v_i = 1'b0;
    logic        commit_v_i = 1'b0;
    logic        roll_v_i = 1'b0;
    logic        clr_v_i = 1'b0;
    logic        issue_v_o;
    logic [31:0] issue_data_o;
    logic        credits_full_o;
    logic        credits_empty_o;

    int n_assert = 0;
    int n_fail   = 0;

    bp_be_issue_buffer #(.els_p(8), .data_width_p(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enq_v_i        (enq_v_i),
        .enq_data_i     (enq_data_i),
        .deq_v_i        (deq_v_i),
        .commit_v_i     (commit_v_i),
        .roll_v_i       (roll_v_i),
        .clr_v_i        (clr_v_i),
        .issue_v_o      (issue_v_o),
        .issue_data_o   (issue_data_o),
        .credits_full_o (credits_full_o),
        .credits_empty_o(credits_empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, return 1ns after the edge with inputs idle.
    task automatic cyc(input logic e, input logic [31:0] d, input logic dq,
                       input logic cm, input logic rl, input logic cl);
        enq_v_i = e; enq_data_i = d; deq_v_i = dq;
        commit_v_i = cm; roll_v_i = rl; clr_v_i = cl;
        @(posedge clk_i); #1;
        enq_v_i = 0; enq_data_i = '0; deq_v_i = 0;
        commit_v_i = 0; roll_v_i = 0; clr_v_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 0;
        check("rst_issue_v", 32'(issue_v_o), 0);
        check("rst_full", 32'(credits_full_o), 0);
        check("rst_empty", 32'(credits_empty_o), 1);

        // Fill A0..A7, then an overflow enqueue
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'hA0 + 32'(i), 0, 0, 0, 0);
            if (i == 0) begin
                check("first_issue_v", 32'(issue_v_o), 1);
                check("first_data", issue_data_o, 32'hA0);
                check("first_empty", 32'(credits_empty_o), 0);
            end
            if (i == 6) check("not_full_at_7", 32'(credits_full_o), 0);
        end
        check("full_after_8", 32'(credits_full_o), 1);
        cyc(1, 32'hFF, 0, 0, 0, 0);
        check("full_after_drop", 32'(credits_full_o), 1);
        check("head_after_drop", issue_data_o, 32'hA0);

        // Dequeue 3, commit 2, roll
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0);
        check("held6_full", 32'(credits_full_o), 0);
        check("held6_data", issue_data_o, 32'hA3);
        cyc(0, 0, 0, 0, 1, 0);
        check("roll_data", issue_data_o, 32'hA2);

        // Roll with a same-cycle commit lands one past the old commit point
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        check("pre_roll_commit", issue_data_o, 32'hA4);
        cyc(0, 0, 0, 1, 1, 0);
        check("roll_commit_data", issue_data_o, 32'hA3);

        // Drain: overflow entry must not appear after A7
        for (int i = 0; i < 5; i++) begin
            check("drain_data", issue_data_o, 32'hA3 + 32'(i));
            cyc(0, 0, 1, 0, 0, 0);
        end
        check("drained_issue_v", 32'(issue_v_o), 0);
        check("drained_not_empty", 32'(credits_empty_o), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        check("all_committed_empty", 32'(credits_empty_o), 1);

        // Streaming enq/deq/commit across two wrap-bit crossings
        for (int k = 0; k < 20; k++) begin
            enq_v_i = 1; enq_data_i = 32'hB0 + 32'(k);
            deq_v_i = 1; commit_v_i = 1;
            if (k >= 1) begin
                check("stream_data", issue_data_o, 32'hB0 + 32'(k - 1));
                check("stream_full", 32'(credits_full_o), 0);
            end
            @(posedge clk_i); #1;
        end
        enq_v_i = 0; enq_data_i = '0; deq_v_i = 0; commit_v_i = 0;
        check("stream_last", issue_data_o, 32'hB0 + 32'd19);
        cyc(0, 0, 1, 1, 0, 0);
        check("stream_last_issue_v", 32'(issue_v_o), 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("stream_empty", 32'(credits_empty_o), 1);

        // Clear beats concurrent enq/deq/commit
        cyc(1, 32'hC0, 0, 0, 0, 0);
        cyc(1, 32'hC1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 32'hC2, 1, 1, 0, 1);
        check("clr_issue_v", 32'(issue_v_o), 0);
        check("clr_empty", 32'(credits_empty_o), 1);
        check("clr_full", 32'(credits_full_o), 0);
        cyc(1, 32'hD0, 0, 0, 0, 0);
        check("post_clr_data", issue_data_o, 32'hD0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("post_clr_empty", 32'(credits_empty_o), 1);

        // Enqueue into an empty buffer with dispatch ready
        enq_v_i = 1; enq_data_i = 32'h55; deq_v_i = 1;
        #1;
`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
        check("byp_issue_v", 32'(issue_v_o), 1);
        check("byp_data", issue_data_o, 32'h55);
`else
        check("nobyp_issue_v", 32'(issue_v_o), 0);
`endif
        @(posedge clk_i); #1;
        enq_v_i = 0; enq_data_i = '0; deq_v_i = 0;
`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
        check("byp_next_issue_v", 32'(issue_v_o), 0);
`else
        check("nobyp_next_issue_v", 32'(issue_v_o), 1);
        check("nobyp_next_data", issue_data_o, 32'h55);
`endif
        check("byp_next_empty", 32'(credits_empty_o), 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("byp_drained_empty", 32'(credits_empty_o), 1);

        // Fill from a non-zero index: full must come from the wrap bit
        for (int i = 0; i < 8; i++) cyc(1, 32'hE0 + 32'(i), 0, 0, 0, 0);
        check("wrapfill_full", 32'(credits_full_o), 1);
        check("wrapfill_empty", 32'(credits_empty_o), 0);
        check("wrapfill_head", issue_data_o, 32'hE0);

        // Reset mid-operation overrides an enqueue
        reset_i = 1;
        cyc(1, 32'h77, 1, 1, 0, 0);
        reset_i = 0;
        check("midrst_issue_v", 32'(issue_v_o), 0);
        check("midrst_empty", 32'(credits_empty_o), 1);
        check("midrst_full", 32'(credits_full_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
